// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target engine.
//   state_t  - protocol state encoding (8 codes, 3 bits)
//   ACK/NACK - SDA level of the acknowledge bit
//   BYTE_W   - bits per I2C byte
package i2c_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      RX       = 3'd3,
      RX_ACK   = 3'd4,
      TX       = 3'd5,
      TX_ACK   = 3'd6,
      WAIT     = 3'd7
   } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings one raw I2C pad line into the clk domain.
// A SYNC_STAGES-deep flop chain is followed by an optional glitch filter
// that needs FILTER_LEN extra consecutive differing samples before the
// accepted level moves (FILTER_LEN = 0 disables it).
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   line_in   - raw pad input
//   level     - accepted (synchronised, filtered) line level
//   rise/fall - one-cycle pulses when level changes
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   accept;

   // Synchroniser chain; resets to the idle-high bus level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   generate
      if (FILTER_LEN == 0) begin : g_nofilt
         assign accept = (synced != level);
      end else begin : g_filt
         localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
         logic [CNT_W-1:0] cnt;

         // Counts samples that disagree with the accepted level.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt <= '0;
            end else if ((synced == level) || accept) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end

         assign accept = (synced != level) && (cnt == CNT_W'(FILTER_LEN));
      end
   endgenerate

   // Accepted level plus registered edge pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (accept) begin
            level <= synced;
            rise  <= synced;
            fall  <= ~synced;
         end
      end
   end

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) engine with 7-bit address match.
// Detects START / repeated START / STOP, ACKs its address, then receives
// (write) or transmits (read) bytes with a byte-level local handshake.
// SDA is only ever pulled low (sda_oe = 1) or released.
// Optional build macro I2C_GENERAL_CALL_EN: address byte 8'h00 is ACKed as
// a write and flagged on gen_call until STOP.
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   scl_in, sda_in    - raw pad inputs
//   sda_oe            - 1 = pull SDA low
//   busy              - addressed transfer in progress (until STOP)
//   rx_data/rx_valid  - received byte and its one-cycle strobe
//   rx_ready          - local side accepts the byte (sampled at bit 8)
//   tx_data/tx_req    - byte to send and its one-cycle request strobe
//   stop_seen         - one-cycle pulse on every STOP
//   gen_call          - general call matched (macro builds only)
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = 7'h42,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              busy,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              tx_req,
   output logic              stop_seen
`ifdef I2C_GENERAL_CALL_EN
   ,
   output logic              gen_call
`endif
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start, stop;

   state_t            state;
   logic [2:0]        bit_cnt;
   logic [BYTE_W-2:0] shreg;
   logic [BYTE_W-1:0] tx_shift;
   logic [BYTE_W-1:0] rx_byte_c;
   logic              rw;
   logic              ack_phase;
   logic              tx_load;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
      .clk     (clk),
      .rst     (rst),
      .line_in (scl_in),
      .level   (scl_lvl),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
      .clk     (clk),
      .rst     (rst),
      .line_in (sda_in),
      .level   (sda_lvl),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   assign start     = sda_fall & scl_lvl;
   assign stop      = sda_rise & scl_lvl;
   assign rx_byte_c = {shreg, sda_lvl};

   // Protocol FSM; START/STOP override any SCL edge in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         tx_shift  <= '0;
         rw        <= 1'b0;
         ack_phase <= 1'b0;
         tx_load   <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         stop_seen <= 1'b0;
`ifdef I2C_GENERAL_CALL_EN
         gen_call  <= 1'b0;
`endif
      end else begin
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         stop_seen <= 1'b0;
         if (stop) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            tx_load   <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            stop_seen <= 1'b1;
`ifdef I2C_GENERAL_CALL_EN
            gen_call  <= 1'b0;
`endif
         end else if (start) begin
            state     <= ADDR;
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            tx_load   <= 1'b0;
            sda_oe    <= 1'b0;
         end else begin
            case (state)
               ADDR: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte_c[BYTE_W-2:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        ack_phase <= 1'b0;
                        if (rx_byte_c[BYTE_W-1:1] == DEV_ADDR) begin
                           state <= ADDR_ACK;
                           busy  <= 1'b1;
                           rw    <= rx_byte_c[0];
`ifdef I2C_GENERAL_CALL_EN
                        end else if (rx_byte_c == 8'h00) begin
                           state    <= ADDR_ACK;
                           busy     <= 1'b1;
                           rw       <= 1'b0;
                           gen_call <= 1'b1;
`endif
                        end else begin
                           state <= WAIT;
                        end
                     end
                  end
               end

               // First fall drives the ACK, second fall ends the ACK clock.
               ADDR_ACK, RX_ACK: begin
                  if (scl_rise && ack_phase && (state == ADDR_ACK) && rw) begin
                     tx_req <= 1'b1;
                  end
                  if (scl_fall) begin
                     if (!ack_phase) begin
                        sda_oe    <= ~ACK;
                        ack_phase <= 1'b1;
                     end else begin
                        ack_phase <= 1'b0;
                        if ((state == ADDR_ACK) && rw) begin
                           state    <= TX;
                           sda_oe   <= ~tx_data[BYTE_W-1];
                           tx_shift <= {tx_data[BYTE_W-2:0], 1'b0};
                        end else begin
                           state  <= RX;
                           sda_oe <= 1'b0;
                        end
                     end
                  end
               end

               RX: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte_c[BYTE_W-2:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rx_data   <= rx_byte_c;
                        rx_valid  <= 1'b1;
                        ack_phase <= 1'b0;
                        state     <= rx_ready ? RX_ACK : WAIT;
                     end
                  end
               end

               // bit_cnt counts bits already clocked out; 0 after a full byte.
               TX: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end else if (scl_fall) begin
                     if (tx_load) begin
                        tx_load  <= 1'b0;
                        sda_oe   <= ~tx_data[BYTE_W-1];
                        tx_shift <= {tx_data[BYTE_W-2:0], 1'b0};
                     end else if (bit_cnt == 3'd0) begin
                        sda_oe <= 1'b0;
                        state  <= TX_ACK;
                     end else begin
                        sda_oe   <= ~tx_shift[BYTE_W-1];
                        tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                     end
                  end
               end

               TX_ACK: begin
                  if (scl_rise) begin
                     if (sda_lvl == ACK) begin
                        tx_req  <= 1'b1;
                        tx_load <= 1'b1;
                        state   <= TX;
                     end else begin
                        state <= WAIT;
                     end
                  end
               end

               default: begin
                  sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target with a bit-banged I2C master.
module tb_i2c_target;

   localparam int Q = 80;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_in;
   logic       sda_m;
   logic       sda_in;
   logic       sda_oe;
   logic       busy;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data = 8'h00;
   logic       tx_req;
   logic       stop_seen;
`ifdef I2C_GENERAL_CALL_EN
   logic       gen_call;
`endif

   int checks = 0;
   int errors = 0;

   int         rx_cnt = 0;
   logic [7:0] rx_last = 8'h00;
   int         tx_req_cnt = 0;
   int         tx_idx = 0;
   int         stop_cnt = 0;
   int         oe_cnt = 0;
   logic [7:0] tx_mem [0:3] = '{8'h96, 8'h0F, 8'h5A, 8'h00};

   assign sda_in = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target dut (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_req    (tx_req),
      .stop_seen (stop_seen)
`ifdef I2C_GENERAL_CALL_EN
      ,
      .gen_call  (gen_call)
`endif
   );

   // Local-side model: logs strobes and serves tx_data on each request.
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt  = rx_cnt + 1;
         rx_last = rx_data;
      end
      if (tx_req) begin
         tx_req_cnt = tx_req_cnt + 1;
         if (tx_idx < 4) tx_data <= tx_mem[tx_idx];
         tx_idx = tx_idx + 1;
      end
      if (stop_seen) stop_cnt = stop_cnt + 1;
      if (sda_oe) oe_cnt = oe_cnt + 1;
   end

   task automatic i2c_start();
      sda_m = 1'b1; #(Q);
      scl_in = 1'b1; #(Q);
      sda_m = 1'b0; #(Q);
      scl_in = 1'b0; #(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #(Q);
      scl_in = 1'b1; #(Q);
      sda_m = 1'b1; #(2*Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; #(Q);
         scl_in = 1'b1; #(2*Q);
         scl_in = 1'b0; #(Q);
      end
      sda_m = 1'b1; #(Q);
      scl_in = 1'b1; #(Q);
      ack = sda_in; #(Q);
      scl_in = 1'b0; #(Q);
   endtask

   task automatic read_byte(output logic [7:0] b, input logic mack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; #(Q);
         scl_in = 1'b1; #(Q);
         b[i] = sda_in; #(Q);
         scl_in = 1'b0; #(Q);
      end
      sda_m = mack; #(Q);
      scl_in = 1'b1; #(2*Q);
      scl_in = 1'b0; #(Q);
   endtask

   task automatic test_reset();
      rst = 1'b1; scl_in = 1'b1; sda_m = 1'b1; rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
      checks++; if ({rx_valid, tx_req, stop_seen} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {rx_valid, tx_req, stop_seen}); end
      rst = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_write();
      logic ack;
      int rc, sc;
      rc = rx_cnt; sc = stop_cnt;
      i2c_start();
      write_byte(8'h84, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b exp 0", ack); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b exp 1", busy); end
      write_byte(8'hA5, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_a5_ack got %b exp 0", ack); end
      checks++; if (rx_cnt != rc + 1 || rx_last !== 8'hA5) begin errors++; $display("FAIL wr_a5_rx got cnt %0d data %h exp cnt %0d data a5", rx_cnt - rc, rx_last, 1); end
      write_byte(8'h3C, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_3c_ack got %b exp 0", ack); end
      checks++; if (rx_cnt != rc + 2 || rx_last !== 8'h3C) begin errors++; $display("FAIL wr_3c_rx got cnt %0d data %h exp cnt 2 data 3c", rx_cnt - rc, rx_last); end
      i2c_stop();
      checks++; if (stop_cnt != sc + 1) begin errors++; $display("FAIL wr_stop_seen got %0d exp 1", stop_cnt - sc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b exp 0", busy); end
   endtask

   task automatic test_addr_mismatch();
      logic ack;
      int rc, oc;
      rc = rx_cnt; oc = oe_cnt;
      i2c_start();
      write_byte(8'h86, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nm_addr_ack got %b exp 1", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nm_busy got %b exp 0", busy); end
      write_byte(8'h55, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nm_data_ack got %b exp 1", ack); end
      checks++; if (oe_cnt != oc || rx_cnt != rc) begin errors++; $display("FAIL nm_quiet got oe %0d rx %0d exp 0 0", oe_cnt - oc, rx_cnt - rc); end
      i2c_stop();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nm_busy_end got %b exp 0", busy); end
   endtask

   task automatic test_read();
      logic ack;
      logic [7:0] b;
      int tc;
      tc = tx_req_cnt;
      i2c_start();
      write_byte(8'h85, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b exp 0", ack); end
      read_byte(b, 1'b0);
      checks++; if (b !== 8'h96) begin errors++; $display("FAIL rd_byte0 got %h exp 96", b); end
      read_byte(b, 1'b1);
      checks++; if (b !== 8'h0F) begin errors++; $display("FAIL rd_byte1 got %h exp 0f", b); end
      checks++; if (tx_req_cnt != tc + 2) begin errors++; $display("FAIL rd_tx_req got %0d exp 2", tx_req_cnt - tc); end
      checks++; if (busy !== 1'b1 || sda_oe !== 1'b0) begin errors++; $display("FAIL rd_wait got busy %b oe %b exp 1 0", busy, sda_oe); end
      i2c_stop();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end got %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic ack;
      logic [7:0] b;
      int tc;
      i2c_start();
      write_byte(8'h84, ack);
      write_byte(8'h11, ack);
      checks++; if (ack !== 1'b0 || rx_last !== 8'h11) begin errors++; $display("FAIL rs_wr got ack %b data %h exp 0 11", ack, rx_last); end
      tc = tx_req_cnt;
      i2c_start();
      write_byte(8'h85, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_rd_addr_ack got %b exp 0", ack); end
      checks++; if (tx_req_cnt != tc + 1) begin errors++; $display("FAIL rs_tx_req got %0d exp 1", tx_req_cnt - tc); end
      read_byte(b, 1'b1);
      checks++; if (b !== 8'h5A) begin errors++; $display("FAIL rs_rd_byte got %h exp 5a", b); end
      i2c_stop();
   endtask

   task automatic test_rx_not_ready();
      logic ack;
      int rc;
      i2c_start();
      write_byte(8'h84, ack);
      rc = rx_cnt;
      rx_ready = 1'b0;
      write_byte(8'h77, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nr_ack got %b exp 1", ack); end
      checks++; if (rx_cnt != rc + 1 || rx_last !== 8'h77) begin errors++; $display("FAIL nr_rx got cnt %0d data %h exp 1 77", rx_cnt - rc, rx_last); end
      rx_ready = 1'b1;
      write_byte(8'h88, ack);
      checks++; if (ack !== 1'b1 || rx_cnt != rc + 1) begin errors++; $display("FAIL nr_ignored got ack %b cnt %0d exp 1 1", ack, rx_cnt - rc); end
      i2c_stop();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nr_busy_end got %b exp 0", busy); end
   endtask

   task automatic test_reset_mid_tx();
      logic ack;
      int sc;
      i2c_start();
      write_byte(8'h85, ack);
      checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL mr_drive_low got %b exp 1", sda_oe); end
      rst = 1'b1;
      #1;
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL mr_release got %b exp 0", sda_oe); end
      checks++; if (busy !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL mr_regs got busy %b data %h exp 0 00", busy, rx_data); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      sc = stop_cnt;
      i2c_stop();
      checks++; if (stop_cnt != sc + 1) begin errors++; $display("FAIL mr_stop got %0d exp 1", stop_cnt - sc); end
      i2c_start();
      write_byte(8'h84, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mr_addr_ack got %b exp 0", ack); end
      write_byte(8'hE1, ack);
      checks++; if (ack !== 1'b0 || rx_last !== 8'hE1) begin errors++; $display("FAIL mr_rx got ack %b data %h exp 0 e1", ack, rx_last); end
      i2c_stop();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy_end got %b exp 0", busy); end
   endtask

   initial begin
      #(5_000_000);
      $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write();
      test_addr_mismatch();
      test_read();
      test_back_to_back();
      test_rx_not_ready();
      test_reset_mid_tx();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
